decode_issue: RTL

DECODE_ISSUE -- requirements
Module: decode_issue

---
 rtl/decode_issue.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/decode_issue.sv
// ----------------------------------------------------------------------------
// decode_issue
//
// Purpose:
//   Decode/issue stage. Takes one instruction from fetch and extracts its
//   register and CSR fields. It resolves each source operand from the
//   youngest matching forwarding source, or from the register file when no
//   source matches. It presents the result to execute through a registered
//   valid/ready output stage with a one-cycle latency.
//
//   A load-use interlock ("hazard") stalls the input. It fires when the
//   winning forwarding match for a live operand has not yet produced its
//   result. While the stage stalls, it drains any held output as a bubble.
//
// Configuration:
//   DECODE_STALL_CNT_EN - when defined, adds the perf_stall_cnt output. This
//                         is a saturating count of cycles with
//                         in_valid & hazard.
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   in_valid / in_ready        fetch-side handshake
//   in_pc, in_instr            instruction address and encoding
//   in_imm, in_csr_rdata       immediate and CSR read data
//   in_zimm_srca, in_is_csr    operand overrides for srca / srcb
//   rf_rd1, rf_rd2             register-file data for rs1 / rs2
//   fwd_valid, fwd_pending     per-source forwarding valid / result-not-ready
//   fwd_dst, fwd_data          per-source packed destination / data
//   flush                      kill held and incoming instruction
//   out_valid / out_ready      execute-side handshake
//   out_*                      registered decoded payload
//   hazard                     combinational load-use interlock
//   perf_stall_cnt             stall counter (only with DECODE_STALL_CNT_EN)
// ----------------------------------------------------------------------------
module decode_issue #(
    parameter int XLEN    = 64,
    parameter int NUM_FWD = 3
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [63:0]             in_pc,
    input  logic [31:0]             in_instr,
    input  logic [XLEN-1:0]         in_imm,
    input  logic [XLEN-1:0]         in_csr_rdata,
    input  logic                    in_zimm_srca,
    input  logic                    in_is_csr,

    input  logic [XLEN-1:0]         rf_rd1,
    input  logic [XLEN-1:0]         rf_rd2,

    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_pending,
    input  logic [NUM_FWD*5-1:0]    fwd_dst,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,

    input  logic                    flush,

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [63:0]             out_pc,
    output logic [31:0]             out_instr,
    output logic [4:0]              out_rs1,
    output logic [4:0]              out_rs2,
    output logic [4:0]              out_dst,
    output logic [11:0]             out_csr,
    output logic [XLEN-1:0]         out_imm,
    output logic [XLEN-1:0]         out_srca,
    output logic [XLEN-1:0]         out_srcb,

    output logic                    hazard
`ifdef DECODE_STALL_CNT_EN
    ,
    output logic [31:0]             perf_stall_cnt
`endif
);

    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      dst;
    logic [11:0]     csr;

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            rs1_pend;
    logic            rs2_pend;
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic            accept;

    assign rs1 = in_instr[19:15];
    assign rs2 = in_instr[24:20];
    assign dst = in_instr[11:7];
    assign csr = in_instr[31:20];

    // Operand forwarding. The loop walks from the oldest source down to the
    // youngest, so a later (lower-index) match overwrites an earlier one.
    // The lowest matching index therefore wins without any priority chain.
    // Register x0 never matches, so it always reads the register file.
    always_comb begin
        rs1_val  = rf_rd1;
        rs2_val  = rf_rd2;
        rs1_pend = 1'b0;
        rs2_pend = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_dst[i*5 +: 5] == rs1) && (rs1 != 5'd0)) begin
                rs1_val  = fwd_data[i*XLEN +: XLEN];
                rs1_pend = fwd_pending[i];
            end
            if (fwd_valid[i] && (fwd_dst[i*5 +: 5] == rs2) && (rs2 != 5'd0)) begin
                rs2_val  = fwd_data[i*XLEN +: XLEN];
                rs2_pend = fwd_pending[i];
            end
        end
    end

    // Final operand selection. An operand replaced by the immediate or by
    // CSR data does not depend on its register, so a pending match on it
    // must not raise the interlock.
    assign srca   = in_zimm_srca ? in_imm       : rs1_val;
    assign srcb   = in_is_csr    ? in_csr_rdata : rs2_val;
    assign hazard = in_valid & ((~in_zimm_srca & rs1_pend) | (~in_is_csr & rs2_pend));

    assign in_ready = (~out_valid | out_ready) & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;

    // Output register stage. Flush wins over everything except reset. A
    // handshake loads a new instruction. An accepted output with nothing
    // new behind it becomes a bubble. Otherwise the held output stays put
    // while downstream stalls. Payload is left alone on flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_instr <= '0;
            out_rs1   <= '0;
            out_rs2   <= '0;
            out_dst   <= '0;
            out_csr   <= '0;
            out_imm   <= '0;
            out_srca  <= '0;
            out_srcb  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            out_instr <= in_instr;
            out_rs1   <= rs1;
            out_rs2   <= rs2;
            out_dst   <= dst;
            out_csr   <= csr;
            out_imm   <= in_imm;
            out_srca  <= srca;
            out_srcb  <= srcb;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DECODE_STALL_CNT_EN
    // Stall cycle counter. It counts every cycle in which a valid
    // instruction is held back by the interlock. It sticks at all-ones
    // instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
        end else if (in_valid && hazard && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
